// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: stage-controller enables, EX/MEM branch result,
// instruction-memory bus, IF/ID register and status outputs.
interface fetch_unit_if;
    // stage controller and EX/MEM
    logic        pc_wren;
    logic        if_id_wren;
    logic        stage_reset_n;
    logic        branch_taken;
    logic [31:0] branch_target;
    // instruction memory
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    // IF/ID register and status
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic        misalign_err;
    logic        seq_err;
    logic [31:0] instret;

    modport master (
        input  pc_wren, if_id_wren, stage_reset_n, branch_taken, branch_target,
        input  imem_rdata,
        output imem_addr, imem_en,
        output if_id_pc, if_id_instr, if_id_valid,
        output halted, misalign_err, seq_err, instret
    );

    modport slave (
        output pc_wren, if_id_wren, stage_reset_n, branch_taken, branch_target,
        output imem_rdata,
        input  imem_addr, imem_en,
        input  if_id_pc, if_id_instr, if_id_valid,
        input  halted, misalign_err, seq_err, instret
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem read strobe, IF/ID register, retire
// counter, halt detection and misaligned-branch trap.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter logic [31:0] HALT_INSN = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_unit_if.master  bus
);

    typedef enum logic [2:0] {
        WAIT_START,
        ISSUE,
        CAPTURE,
        WAIT_PC,
        HALTED
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        imem_en;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic        misalign_err;
    logic        seq_err;
    logic [31:0] instret;

    logic        target_misaligned;
    assign target_misaligned = |bus.branch_target[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT_START;
            pc           <= RESET_PC;
            imem_en      <= 1'b0;
            if_id_pc     <= 32'h0;
            if_id_instr  <= 32'h0;
            if_id_valid  <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            seq_err      <= 1'b0;
            instret      <= 32'h0;
        end else begin
            // imem_en is a registered one-cycle pulse covering the ISSUE state
            imem_en <= 1'b0;

            if (bus.if_id_wren && state != CAPTURE)
                seq_err <= 1'b1;

            unique case (state)
                WAIT_START: begin
                    if (!bus.stage_reset_n) begin
                        state   <= ISSUE;
                        imem_en <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (bus.if_id_wren) begin
                        if_id_instr <= bus.imem_rdata;
                        if_id_pc    <= pc;
                        if_id_valid <= 1'b1;
                        if (bus.imem_rdata == HALT_INSN) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            state  <= WAIT_PC;
                        end
                    end else begin
                        seq_err <= 1'b1;
                        state   <= WAIT_START;
                    end
                end
                WAIT_PC: begin
                    if (bus.pc_wren) begin
                        if (!bus.branch_taken) begin
                            pc <= pc + 32'd4;
                        end else if (target_misaligned) begin
                            pc           <= TRAP_VEC;
                            misalign_err <= 1'b1;
                        end else begin
                            pc <= bus.branch_target;
                        end
                        instret <= instret + 32'd1;
                        state   <= WAIT_START;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= WAIT_START;
                end
            endcase

            // Stage clear overrides a same-cycle capture; data fields hold.
            if (!bus.stage_reset_n)
                if_id_valid <= 1'b0;
        end
    end

    assign bus.imem_addr    = pc;
    assign bus.imem_en      = imem_en;
    assign bus.if_id_pc     = if_id_pc;
    assign bus.if_id_instr  = if_id_instr;
    assign bus.if_id_valid  = if_id_valid;
    assign bus.halted       = halted;
    assign bus.misalign_err = misalign_err;
    assign bus.seq_err      = seq_err;
    assign bus.instret      = instret;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multi-cycle core: owns the program counter, issues the instruction-memory read, and loads the IF/ID pipeline register. It sits directly downstream of the stage controller, consuming `pc_wren`, `if_id_wren` and `stage_reset_n`. It sits upstream of decode, feeding `if_id_pc` and `if_id_instr`. It also tracks retired instructions, detects the halt instruction and traps misaligned branch targets.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `TRAP_VEC`, 32'h0000_0100: PC loaded on a misaligned branch target.
- `HALT_INSN`, 32'h0000_0000: encoding that halts fetch.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pc_wren`  in  1  PC update enable, from the stage controller (MEM stage).
- `if_id_wren`  in  1  IF/ID load enable, from the stage controller (IF_WAIT stage).
- `stage_reset_n`  in  1  active-low synchronous stage clear, from the stage controller.
- `branch_taken`  in  1  from EX/MEM register; valid while `pc_wren`=1.
- `branch_target`  in  32  from EX/MEM register; valid while `pc_wren`=1.
- `imem_addr`  out  32  instruction address; equals `pc` at all times.
- `imem_en`  out  1  read strobe to synchronous instruction memory.
- `imem_rdata`  in  32  read data; valid the cycle after `imem_en`.
- `if_id_pc`  out  32  PC of the captured instruction.
- `if_id_instr`  out  32  captured instruction.
- `if_id_valid`  out  1  IF/ID contents valid.
- `halted`  out  1  sticky; the halt instruction has been fetched.
- `misalign_err`  out  1  sticky; a taken branch had `branch_target[1:0]`≠0.
- `seq_err`  out  1  sticky; `if_id_wren` was absent in CAPTURE or arrived outside CAPTURE.
- `instret`  out  32  retired-instruction counter.

## Operation
- The FSM has five states: WAIT_START, ISSUE, CAPTURE, WAIT_PC, HALTED.
- **WAIT_START:** `stage_reset_n`=0 moves to ISSUE. Otherwise the FSM holds.
- **ISSUE:** `imem_en`=1 for exactly this cycle, then unconditionally to CAPTURE.
- **CAPTURE:** if `if_id_wren`=1:
  - `if_id_instr`←`imem_rdata`, `if_id_pc`←`pc`, `if_id_valid`←1.
  - If `imem_rdata`==`HALT_INSN`, then `halted`←1 and the FSM goes to HALTED.
  - Otherwise the FSM goes to WAIT_PC.
- **CAPTURE with `if_id_wren`=0:** `seq_err`←1, no capture, FSM goes to WAIT_START.
- **WAIT_PC:** on `pc_wren`=1 the PC and counter update as below, then the FSM goes to WAIT_START.
  - If `branch_taken`=0, `pc`←`pc`+4.
  - If `branch_taken`=1 and `branch_target[1:0]`=0, `pc`←`branch_target`.
  - If `branch_taken`=1 and `branch_target[1:0]`≠0, `pc`←`TRAP_VEC` and `misalign_err`←1.
  - `instret`←`instret`+1.
- **HALTED:** absorbing. `imem_en` stays 0, `pc_wren` is ignored, and `instret` is frozen. Only `reset_n` exits.
- **Stage clear:** `stage_reset_n`=0 in any state clears `if_id_valid` synchronously. `if_id_pc` and `if_id_instr` hold their values. `pc`, the counters and the sticky flags are unaffected.
- **Stray enables:** `pc_wren` outside WAIT_PC is ignored. `if_id_wren` outside CAPTURE is ignored and sets `seq_err`.
- **Arithmetic:** `pc`+4 and `instret`+1 are modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- **Reset values:**
  - `pc`=`RESET_PC`, FSM=WAIT_START.
  - `imem_en`=0, `if_id_pc`=0, `if_id_instr`=0, `if_id_valid`=0.
  - `halted`=0, `misalign_err`=0, `seq_err`=0, `instret`=0.
- **Reset assertion** is asynchronous and mid-operation abandons any fetch immediately. Deassertion is sampled on the next rising edge.
- **Nominal 8-cycle controller sequence** (INIT/WB, IF, IF_WAIT, ID, EX, MEM, MEM_WAIT, WB):
  - `stage_reset_n`=0 in INIT/WB → ISSUE in IF (`imem_en`=1).
  - CAPTURE in IF_WAIT; `if_id_*` are visible from the ID cycle.
  - WAIT_PC through ID/EX/MEM; the new `pc` is visible from the MEM_WAIT cycle.
  - `stage_reset_n`=0 in WB returns the FSM to ISSUE in the next IF.
- **Fetch latency:** instruction-memory data is consumed exactly 1 cycle after `imem_en`.
- `imem_addr` and `if_id_*` are registered outputs with no combinational path from inputs.

## Test plan
- **Reset then two nominal sequences, `branch_taken`=0, instr 32'h0010_0093:**
  - `imem_en` pulses at addresses 0 then 4.
  - `if_id_pc`=0 then 4, `instret`=2, all error flags 0.
- **Taken branch to 32'h0000_0040:** the next `imem_addr` is 32'h40. Target 32'h0000_0042 instead gives `pc`=32'h100 and `misalign_err`=1.
- **Fetch returns `HALT_INSN`:** `halted`=1 and `imem_en` stays 0. Further `pc_wren` pulses leave `pc` and `instret` unchanged.
- **Missing `if_id_wren` during CAPTURE:** `seq_err`=1, `if_id_valid` stays 0, and the next `stage_reset_n` pulse resumes fetch at the same `pc`.
- **`reset_n` asserted in WAIT_PC with `pc`=32'h20:** all outputs take their reset values without a clock edge, and fetch restarts at `RESET_PC`.
- **Wrap:** `pc`=32'hFFFF_FFFC with a not-taken `pc_wren` gives `pc`=0. `instret` preloaded to 32'hFFFF_FFFF wraps to 0.
